// File: rtl/rv_mc_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, owns the memory handshake and watchdog, and counts retirements.
module rv_mc_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  // Handshake: a memory transfer completes in any cycle where mem_req and mem_ready
  // are both high; mem_req stays high until then and drops the cycle after.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q;
  cls_t            cls_q;
  cls_t            dec_cls;
  logic [TO_W-1:0] to_cnt;
  logic            trap_q;
  logic [1:0]      cause_q;
  logic [CNT_W-1:0] retired_q;
  logic            handshake;
  logic            waiting;
  logic            timeout_hit;
  logic            retire_now;

  always_comb begin
    dec_cls = C_ILL;
    if (opcode[1:0] == 2'b11) begin
      case (opcode[6:2])
        5'b01100: dec_cls = C_R;
        5'b00100: dec_cls = C_IALU;
        5'b00000: dec_cls = C_LOAD;
        5'b01000: dec_cls = C_STORE;
        5'b11000: dec_cls = C_BRANCH;
        5'b11011: dec_cls = C_JAL;
        5'b11001: dec_cls = C_JALR;
        5'b01101: dec_cls = C_LUI;
        5'b00101: dec_cls = C_AUIPC;
        default:  dec_cls = C_ILL;
      endcase
    end
  end

  // Strobes that depend on mem_ready or branch_cond must act in the same cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        if (cls_q == C_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_cond ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == C_STORE);
        if (cls_q == C_STORE && mem_ready) pc_write = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (cls_q == C_LOAD);
        pc_write  = 1'b1;
        if (cls_q == C_JAL)       pc_src = 2'b01;
        else if (cls_q == C_JALR) pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  assign handshake   = mem_req && mem_ready;
  assign waiting     = mem_req && !mem_ready;
  assign timeout_hit = waiting && (to_cnt == TO_LAST);
  assign retire_now  = (state_q == S_EXEC && cls_q == C_BRANCH) ||
                       (state_q == S_MEM && cls_q == C_STORE && mem_ready) ||
                       (state_q == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ILL;
      to_cnt    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      retired_q <= '0;
    end else begin
      if (handshake)    to_cnt <= '0;
      else if (waiting) to_cnt <= to_cnt + TO_W'(1);
      if (retire_now)   retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        S_IDLE: if (run) state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
          else if (timeout_hit) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
          end
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          if (dec_cls == C_ILL) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b01;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls_q == C_BRANCH)                      state_q <= run ? S_FETCH : S_IDLE;
          else if (cls_q == C_LOAD || cls_q == C_STORE) state_q <= S_MEM;
          else                                         state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (cls_q == C_STORE) state_q <= run ? S_FETCH : S_IDLE;
            else                  state_q <= S_WB;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
          end
        end
        S_WB:    state_q <= run ? S_FETCH : S_IDLE;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Directed, table-driven bench for rv_mc_sequencer with a few hand-written multi-cycle sequences.
module tb_rv_mc_sequencer;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_ILL  = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        branch_cond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_write, pc_write, reg_write, wb_sel, trap;
  logic [1:0]  pc_src, trap_cause;
  logic [31:0] retired;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  rv_mc_sequencer #(.CNT_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .trap(trap), .trap_cause(trap_cause), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  // exp layout: {state, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, trap, trap_cause}
  typedef struct packed {
    logic        rst;
    logic        run;
    logic [6:0]  op;
    logic        bc;
    logic        rdy;
    logic [13:0] exp;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [13:0] ex(input int st, input int req, input int we, input int irw,
                                     input int pcw, input int pcs, input int rw, input int wbs,
                                     input int tr, input int ca);
    return {3'(st), 1'(req), 1'(we), 1'(irw), 1'(pcw), 2'(pcs), 1'(rw), 1'(wbs), 1'(tr), 2'(ca)};
  endfunction

  function automatic vec_t mk(input logic r, input logic ru, input logic [6:0] op,
                              input logic bc, input logic rdy, input logic [13:0] e,
                              input int ret);
    vec_t v;
    v.rst = r; v.run = ru; v.op = op; v.bc = bc; v.rdy = rdy; v.exp = e; v.ret = 32'(ret);
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {state, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, trap, trap_cause};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    rst = v.rst; run = v.run; opcode = v.op; branch_cond = v.bc; mem_ready = v.rdy;
    @(negedge clk);
    check($sformatf("row%0d_outs", idx), 32'(outs()), 32'(v.exp));
    check($sformatf("row%0d_retired", idx), retired, v.ret);
  endtask

  initial begin
    // reset, then ADD with zero-wait memory
    tbl.push_back(mk(1, 0, OP_ADD, 0, 0, ex(0,0,0,0,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ADD, 0, 1, ex(0,0,0,0,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ADD, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ADD, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ADD, 0, 1, ex(3,0,0,0,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ADD, 0, 1, ex(5,0,0,0,1,0,1,0,0,0), 0));
    // LOAD with three wait cycles in MEM, run dropped at retire
    tbl.push_back(mk(0, 1, OP_LD, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 1));
    tbl.push_back(mk(0, 1, OP_LD, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 1));
    tbl.push_back(mk(0, 1, OP_LD, 0, 1, ex(3,0,0,0,0,0,0,0,0,0), 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, OP_LD, 0, 0, ex(4,1,0,0,0,0,0,0,0,0), 1));
    tbl.push_back(mk(0, 1, OP_LD, 0, 1, ex(4,1,0,0,0,0,0,0,0,0), 1));
    tbl.push_back(mk(0, 0, OP_LD, 0, 1, ex(5,0,0,0,1,0,1,1,0,0), 1));
    tbl.push_back(mk(0, 0, OP_BR, 0, 1, ex(0,0,0,0,0,0,0,0,0,0), 2));
    tbl.push_back(mk(0, 1, OP_BR, 0, 1, ex(0,0,0,0,0,0,0,0,0,0), 2));
    // BRANCH taken, then not taken
    tbl.push_back(mk(0, 1, OP_BR, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 2));
    tbl.push_back(mk(0, 1, OP_BR, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 2));
    tbl.push_back(mk(0, 1, OP_BR, 1, 1, ex(3,0,0,0,1,1,0,0,0,0), 2));
    tbl.push_back(mk(0, 1, OP_BR, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 3));
    tbl.push_back(mk(0, 1, OP_BR, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 3));
    tbl.push_back(mk(0, 1, OP_BR, 0, 1, ex(3,0,0,0,1,0,0,0,0,0), 3));
    // JALR then JAL
    tbl.push_back(mk(0, 1, OP_JALR, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 4));
    tbl.push_back(mk(0, 1, OP_JALR, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 4));
    tbl.push_back(mk(0, 1, OP_JALR, 0, 1, ex(3,0,0,0,0,0,0,0,0,0), 4));
    tbl.push_back(mk(0, 1, OP_JALR, 0, 1, ex(5,0,0,0,1,2,1,0,0,0), 4));
    tbl.push_back(mk(0, 1, OP_JAL, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 5));
    tbl.push_back(mk(0, 1, OP_JAL, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 5));
    tbl.push_back(mk(0, 1, OP_JAL, 0, 1, ex(3,0,0,0,0,0,0,0,0,0), 5));
    tbl.push_back(mk(0, 1, OP_JAL, 0, 1, ex(5,0,0,0,1,1,1,0,0,0), 5));
    // STORE with one wait cycle
    tbl.push_back(mk(0, 1, OP_ST, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 6));
    tbl.push_back(mk(0, 1, OP_ST, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 6));
    tbl.push_back(mk(0, 1, OP_ST, 0, 1, ex(3,0,0,0,0,0,0,0,0,0), 6));
    tbl.push_back(mk(0, 1, OP_ST, 0, 0, ex(4,1,1,0,0,0,0,0,0,0), 6));
    tbl.push_back(mk(0, 1, OP_ST, 0, 1, ex(4,1,1,0,1,0,0,0,0,0), 6));
    // LOAD aborted by reset while waiting in MEM
    tbl.push_back(mk(0, 1, OP_LD, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 7));
    tbl.push_back(mk(0, 1, OP_LD, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 7));
    tbl.push_back(mk(0, 1, OP_LD, 0, 1, ex(3,0,0,0,0,0,0,0,0,0), 7));
    tbl.push_back(mk(0, 1, OP_LD, 0, 0, ex(4,1,0,0,0,0,0,0,0,0), 7));
    tbl.push_back(mk(1, 1, OP_LD, 0, 0, ex(0,0,0,0,0,0,0,0,0,0), 0));
    // illegal opcode trap, run toggling ignored, reset clears
    tbl.push_back(mk(0, 1, OP_ILL, 0, 1, ex(0,0,0,0,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ILL, 0, 1, ex(1,1,0,1,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ILL, 0, 1, ex(2,0,0,0,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 0, OP_ILL, 0, 1, ex(6,0,0,0,0,0,0,0,1,1), 0));
    tbl.push_back(mk(0, 1, OP_ILL, 0, 1, ex(6,0,0,0,0,0,0,0,1,1), 0));
    tbl.push_back(mk(0, 0, OP_ILL, 0, 1, ex(6,0,0,0,0,0,0,0,1,1), 0));
    tbl.push_back(mk(1, 0, OP_ADD, 0, 1, ex(0,0,0,0,0,0,0,0,0,0), 0));
    // fetch timeout: four request cycles then trap cause 10
    tbl.push_back(mk(0, 1, OP_ADD, 0, 0, ex(0,0,0,0,0,0,0,0,0,0), 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, OP_ADD, 0, 0, ex(1,1,0,0,0,0,0,0,0,0), 0));
    tbl.push_back(mk(0, 1, OP_ADD, 0, 0, ex(6,0,0,0,0,0,0,0,1,2), 0));
    tbl.push_back(mk(0, 1, OP_ADD, 0, 1, ex(6,0,0,0,0,0,0,0,1,2), 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // back-to-back ADDs: three retirements 13 cycles after reset release
    begin
      int n;
      bit done;
      @(posedge clk); #1;
      rst = 1'b1; run = 1'b1; opcode = OP_ADD; mem_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
        @(posedge clk); #1;
        n++;
        if (retired == 32'd3) done = 1'b1;
      end
      check("b2b_cycles", 32'(n), 32'd13);
      check("b2b_state", 32'(state), 32'd1);
      check("b2b_no_trap", 32'(trap), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_mc_sequencer.md
Name: rv_mc_sequencer

Overview:
Multi-cycle control sequencer for the RV32I core. Steps the shared datapath (IR, PC, ALU, register file, single memory port) through FETCH/DECODE/EXEC/MEM/WB for one instruction at a time. Owns the memory request handshake and a timeout watchdog. Raises a trap on an illegal opcode or a memory timeout, and counts retired instructions. The combinational instruction decoder still drives ALU_OP and ALU_SRC; this block drives only the sequencing strobes.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps).
TIMEOUT, 64, max cycles mem_req may wait for mem_ready before trap (>=2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; enables fetching of the next instruction
opcode  in  7  IR[6:0], valid from DECODE onward
branch_cond  in  1  ALU compare result, valid in EXEC
mem_ready  in  1  memory accepts/completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  1 = store, 0 = read (fetch/load)
ir_write  out  1  latch memory read data into IR
pc_write  out  1  update PC
pc_src  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
reg_write  out  1  register file write strobe
wb_sel  out  1  0 = ALU result, 1 = memory data
trap  out  1  sticky trap flag
trap_cause  out  2  01 illegal opcode, 10 memory timeout
retired  out  CNT_W  retired instruction count
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all strobes 0.
  - trap=0, trap_cause=0, retired=0; timeout counter cleared.
  - Reset mid-instruction aborts it immediately; no partial PC or register update.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - mem_req=1, mem_we=0.
  - Cycle with mem_ready=1: ir_write=1 for that cycle only; next state DECODE.
- DECODE:
  - Class is taken from opcode[6:2]: R 01100, I-ALU 00100, LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, LUI 01101, AUIPC 00101.
  - opcode[1:0] != 11, or any other opcode[6:2]: go to TRAP with cause 01.
  - Otherwise go to EXEC. Always exactly 1 cycle.
- EXEC (1 cycle):
  - BRANCH: pc_write=1, pc_src=01 if branch_cond else 00; instruction retires; next state is FETCH if run=1, else IDLE.
  - LOAD and STORE: next state MEM.
  - All other classes: next state WB.
- MEM:
  - mem_req=1; mem_we=1 for STORE, 0 for LOAD.
  - Cycle with mem_ready=1, STORE: pc_write=1, pc_src=00; retire; next state FETCH or IDLE per run.
  - Cycle with mem_ready=1, LOAD: next state WB.
- WB (1 cycle):
  - reg_write=1; wb_sel=1 for LOAD, else 0.
  - pc_write=1 with pc_src=01 for JAL, 10 for JALR, 00 otherwise.
  - Retire; next state FETCH if run=1, else IDLE.
- Handshake rules:
  - mem_req is held high until mem_ready is sampled high; it drops in the following cycle.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - A counter increments on each mem_req=1 && mem_ready=0 cycle and clears on handshake.
  - When it reaches TIMEOUT, go to TRAP with cause 10 next cycle; mem_req drops.
- Retire:
  - retired increments by exactly 1 in the retiring cycle; wraps modulo 2^CNT_W.
  - Trapped instructions do not retire.
- TRAP:
  - Terminal; all strobes 0; trap=1; trap_cause held.
  - Exits only via rst; run is ignored.
- run is sampled only in IDLE and at retire. Deasserting run mid-instruction does not abort it.
- At most one of pc_write, ir_write, reg_write-only paths per state as listed. pc_write and reg_write coincide only in WB.
- Latency with zero-wait memory (mem_ready high on the first request cycle):
  - ALU / LUI / AUIPC / JAL / JALR: 4 cycles (F, D, E, W).
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Test Plan:
- Reset, run=1, mem_ready always 1, opcode=0110011 (ADD) -> states 1,2,3,5,1; ir_write in cycle 1; reg_write=1, pc_write=1, pc_src=00 in WB; retired=1 after 4 cycles.
- LOAD opcode 0000011, mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles with mem_we=0; WB has wb_sel=1, reg_write=1; 8 cycles total.
- BRANCH 1100011: branch_cond=1 -> pc_src=01, no reg_write; branch_cond=0 -> pc_src=00; both retire in EXEC, 3 cycles each.
- JALR 1100111 -> WB asserts reg_write=1, pc_write=1, pc_src=10; JAL 1101111 -> pc_src=01.
- opcode=0000000 -> TRAP after DECODE, trap_cause=01, retired unchanged; run toggling has no effect; rst returns to IDLE with trap=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> 4 request cycles, then TRAP cause=10, mem_req=0. Separately, assert rst mid-MEM -> state=0 immediately, no pc_write.
